uart_tx_fifo: RTL

Serial transmit stage directly downstream of the Hamming decoder in transceiver_top.
- Accepts decoded 8-bit bytes (decoder_out qualified by data_valid) into a small FIFO.
- Serialises each byte as a standard 8N1 UART frame on a single output line.
- Closes the loop so recovered data leaves the chip in the same format uart_rx accepts at the input.

---
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. The default frame is 8N1.
// Defining UART_TX_PARITY_EN inserts an even-parity bit, which makes the frame 8E1.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       active,
    output logic       done,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    data_reg;
    logic          baud_last;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign baud_last = (baud == BAUD_LAST);
    // A byte leaves the FIFO from IDLE, or from the last stop cycle so that frames run back to back.
    assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_last));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && full)
                overflow <= 1'b1;
        end
    end

    // The registered line outputs show the state of the previous cycle.
    // This is why tx falls one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            data_reg <= '0;
            tx       <= 1'b1;
            active   <= 1'b0;
            done     <= 1'b0;
        end else begin
            active <= (state != IDLE);
            done   <= (state == STOP) && baud_last;

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        data_reg <= mem[rd_ptr];
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    tx <= data_reg[bit_idx];
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx <= ^data_reg;
                    if (baud_last) begin
                        baud  <= '0;
                        state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud <= '0;
                        if (pop) begin
                            data_reg <= mem[rd_ptr];
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
